mult_pipe_ctrl: RTL and testbench

- Sequencer and flow controller for the pipelined multiplier datapath: the partial-product generator followed by the HA/FA reduction stages and the final adder.
- Accepts operand pairs through a valid/ready handshake and registers the operands that drive the datapath.
- Drives the per-stage register enables, with bubble collapsing and backpressure.
- Handles signed operation by sign-magnitude conversion, and buffers finished products in a small output FIFO.
- Sits between the execute-stage issue logic and the multiplier datapath.

---
 rtl/mult_pipe_ctrl.sv | 125 ++++++++++++
 tb/tb_mult_pipe_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_ctrl.sv
// Flow controller for a pipelined multiplier: operand handshake, sign-magnitude
// conditioning, per-bank load enables with bubble collapse, and a result FIFO.
module mult_pipe_ctrl #(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic [STAGES-1:0]    stage_en,
  input  logic [2*WIDTH-1:0]   dp_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy
);

  localparam int PW   = 2 * WIDTH;
  localparam int CW   = $clog2(OUT_DEPTH + 1);
  localparam int PTRW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  function automatic logic [WIDTH-1:0] to_mag(input logic signed [WIDTH-1:0] x,
                                               input logic sgn_mode);
    logic [WIDTH-1:0] u;
    u = x;
    // The most negative value wraps onto itself, which read as unsigned is 2^(WIDTH-1).
    return (sgn_mode && u[WIDTH-1]) ? (~u + WIDTH'(1)) : u;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p, input logic neg);
    return neg ? (~p + PW'(1)) : p;
  endfunction

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p == PTRW'(OUT_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  logic signed [WIDTH-1:0] w_a_s, w_b_s;
  logic [WIDTH-1:0]        r_op_a_p0, r_op_b_p0;
  logic [STAGES-1:0]       r_vld, r_sgn, w_adv;
  logic [PW-1:0]           r_fifo_mem [OUT_DEPTH];
  logic [PTRW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    w_load, w_push, w_pop, w_fifo_wr_ok, w_sign_in;

  assign w_a_s     = in_a;
  assign w_b_s     = in_b;
  assign w_sign_in = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

  assign out_valid   = (r_count != '0);
  assign out_product = r_fifo_mem[r_rd_ptr];
  assign w_pop       = out_valid & out_ready;
  assign busy        = (|r_vld) | (r_count != '0);

  // Advance chain is resolved from the output end back toward bank 0.
  always_comb begin
    w_fifo_wr_ok = (r_count < CW'(OUT_DEPTH)) | w_pop;
    w_adv        = '0;
    w_adv[STAGES-1] = r_vld[STAGES-1] & w_fifo_wr_ok;
    for (int i = STAGES - 2; i >= 0; i--) begin
      w_adv[i] = r_vld[i] & (~r_vld[i+1] | w_adv[i+1]);
    end
  end

  assign in_ready = ~r_vld[0] | w_adv[0];
  assign w_load   = in_valid & in_ready;
  assign w_push   = w_adv[STAGES-1];
  assign op_a     = r_op_a_p0;
  assign op_b     = r_op_b_p0;

  always_comb begin
    stage_en    = '0;
    stage_en[0] = w_load;
    for (int i = 1; i < STAGES; i++) begin
      stage_en[i] = w_adv[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld     <= '0;
      r_sgn     <= '0;
      r_op_a_p0 <= '0;
      r_op_b_p0 <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      for (int k = 0; k < OUT_DEPTH; k++) begin
        r_fifo_mem[k] <= '0;
      end
    end else begin
      // Stage 0: operand capture
      r_vld[0] <= w_load | (r_vld[0] & ~w_adv[0]);
      if (w_load) begin
        r_op_a_p0 <= to_mag(w_a_s, in_signed);
        r_op_b_p0 <= to_mag(w_b_s, in_signed);
        r_sgn[0]  <= w_sign_in;
      end
      // Stages 1..STAGES-1: valid/sign tracking alongside the datapath banks
      for (int i = 1; i < STAGES; i++) begin
        r_vld[i] <= w_adv[i-1] | (r_vld[i] & ~w_adv[i]);
        if (w_adv[i-1]) begin
          r_sgn[i] <= r_sgn[i-1];
        end
      end
      // Output FIFO
      if (w_push) begin
        r_fifo_mem[r_wr_ptr] <= apply_sign(dp_product, r_sgn[STAGES-1]);
        r_wr_ptr             <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_mult_pipe_ctrl.sv
// Scoreboard bench for mult_pipe_ctrl with a behavioural datapath stub and
// a product reference model computed from the operands at handshake time.
module tb_mult_pipe_ctrl;
  localparam int W  = 8;
  localparam int ST = 4;
  localparam int OD = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_a = '0;
  logic [W-1:0]    in_b = '0;
  logic            in_signed = 1'b0;
  logic [W-1:0]    op_a, op_b;
  logic [ST-1:0]   stage_en;
  logic [2*W-1:0]  dp_product;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*W-1:0]  out_product;
  logic            busy;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  logic [2*W-1:0] exp_q [$];

  mult_pipe_ctrl #(.WIDTH(W), .STAGES(ST), .OUT_DEPTH(OD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .op_a(op_a), .op_b(op_b),
    .stage_en(stage_en), .dp_product(dp_product), .out_valid(out_valid),
    .out_ready(out_ready), .out_product(out_product), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath stub: banks 1..ST-1 load under stage_en, last bank feeds dp_product.
  logic [2*W-1:0] dp_bank [1:ST-1];
  always @(posedge clk) begin
    if (stage_en[1]) dp_bank[1] <= 16'(op_a) * 16'(op_b);
    for (int i = 2; i < ST; i++) begin
      if (stage_en[i]) dp_bank[i] <= dp_bank[i-1];
    end
  end
  assign dp_product = dp_bank[ST-1];

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    logic signed [2*W-1:0] sa, sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Monitor: record accepted pairs, compare every popped result.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        logic [2*W-1:0] e;
        n_pop++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got %04h with no expected result", out_product);
        end else begin
          e = exp_q.pop_front();
          if (out_product !== e) begin
            bad++;
            $display("FAIL sb_product: got %04h expected %04h", out_product, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_prod(in_a, in_b, in_signed));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic wait_out(input string name, input logic [2*W-1:0] exp);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      if (out_valid) seen = 1'b1;
      else step();
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    check(name, 32'(out_product), 32'(exp));
    step();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      step();
      done = (exp_q.size() == 0) && !busy;
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    int acc, drops, run, maxrun, pops0;

    repeat (3) step();
    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stage_en", 32'(stage_en), 32'd0);
    check("rst_op_a", 32'(op_a), 32'd0);
    check("rst_out_product", 32'(out_product), 32'd0);
    reset = 1'b0;

    // Unsigned 200*150 with exact latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'd200; in_b = 8'd150; in_signed = 1'b0;
    #3;
    check("u_in_ready", 32'(in_ready), 32'd1);
    check("u_stage_en0", 32'(stage_en[0]), 32'd1);
    step();
    in_valid = 1'b0;
    check("u_op_a", 32'(op_a), 32'd200);
    check("u_op_b", 32'(op_b), 32'd150);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("u_latency_low", 32'(out_valid), 32'd0);
    end
    step();
    check("u_latency_high", 32'(out_valid), 32'd1);
    check("u_product", 32'(out_product), 32'h7530);
    check("u_busy_pre_pop", 32'(busy), 32'd1);
    step();
    check("u_busy_after_pop", 32'(busy), 32'd0);
    check("u_valid_after_pop", 32'(out_valid), 32'd0);

    // Signed corner cases
    send(8'h80, 8'h80, 1'b1);
    check("s_op_a_min", 32'(op_a), 32'h80);
    check("s_op_b_min", 32'(op_b), 32'h80);
    wait_out("s_min_min", 16'h4000);
    send(8'h80, 8'h7F, 1'b1);
    wait_out("s_min_max", 16'hC080);
    send(8'h00, 8'hFB, 1'b1);
    wait_out("s_zero_neg", 16'h0000);
    send(8'hFD, 8'h05, 1'b1);
    wait_out("s_neg3_5", 16'hFFF1);
    drain();

    // Back-to-back stream of 10 unsigned pairs
    drops = 0; run = 0; maxrun = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = (cyc < 10);
      in_a = W'($urandom); in_b = W'($urandom); in_signed = 1'b0;
      @(negedge clk);
      if (cyc < 10 && !in_ready) drops++;
      if (out_valid) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      step();
    end
    in_valid = 1'b0;
    check("stream_in_ready_drops", 32'(drops), 32'd0);
    check("stream_consecutive_valid", 32'(maxrun), 32'd10);
    drain();

    // Backpressure: capacity is STAGES + OUT_DEPTH
    out_ready = 1'b0;
    acc = 0;
    pops0 = n_pop;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = 1'b1;
      in_a = W'($urandom); in_b = W'($urandom); in_signed = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'(ST + OD));
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    #2;
    check("bp_in_ready_release", 32'(in_ready), 32'd1);
    drain();
    check("bp_pops", 32'(n_pop - pops0), 32'(ST + OD));

    // Random traffic with alternating output stalls
    pops0 = n_pop;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_signed = 1'($urandom_range(0, 1));
      out_ready = (cyc % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      step();
    end
    drain();
    check("rand_wraps", 32'((n_pop - pops0) >= 4 * OD), 32'd1);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with results in flight and buffered
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(W'($urandom), W'($urandom), 1'b0);
    step();
    check("mid_fifo_full", 32'(out_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_stage_en", 32'(stage_en), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    pops0 = n_pop;
    repeat (12) step();
    check("mid_rst_no_stale", 32'(n_pop - pops0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
